syncfifo_shared_n: RTL and testbench

- NCH independent FIFO channels sharing one DEPTH-entry data pool, generalising the fixed 5-channel shared FIFO.
- Each channel keeps a pointer queue of the pool slots it holds, in order; a free mask tracks unoccupied slots.
- Adds three things:
  - a guaranteed per-channel reservation (RESERVE slots);
  - deterministic same-cycle allocation;
  - per-channel counts and a sticky drop/underflow error.
- Sits between multi-source producers and per-destination consumers.

---
 rtl/syncfifo_shared_n_if.sv | 28 ++
 rtl/syncfifo_shared_n.sv | 149 ++++++++++++++
 tb/tb_syncfifo_shared_n.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/syncfifo_shared_n_if.sv
// rtl/syncfifo_shared_n_if.sv - producer/consumer bundle for the shared-pool multi-channel FIFO
interface syncfifo_shared_n_if #(
   parameter int WID   = 32,
   parameter int DEPTH = 8,
   parameter int NCH   = 5
);
   localparam int CWID = $clog2(DEPTH + 1);

   logic [NCH-1:0]      vldin;
   logic [NCH*WID-1:0]  din;
   logic [NCH-1:0]      readout;
   logic [NCH*WID-1:0]  dout;
   logic [NCH-1:0]      full;
   logic [NCH-1:0]      empty;
   logic [NCH*CWID-1:0] count;
   logic [CWID-1:0]     free_count;
   logic [1:0]          err;

   modport master (
      output vldin, din, readout,
      input  dout, full, empty, count, free_count, err
   );

   modport slave (
      input  vldin, din, readout,
      output dout, full, empty, count, free_count, err
   );
endinterface

// File: rtl/syncfifo_shared_n.sv
// rtl/syncfifo_shared_n.sv - NCH FIFO channels sharing one DEPTH-entry pool with per-channel reservation
module syncfifo_shared_n #(
   parameter int WID     = 32,
   parameter int DEPTH   = 8,
   parameter int NCH     = 5,
   parameter int RESERVE = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                softreset,
   syncfifo_shared_n_if.slave  bus
);
   localparam int AWID = $clog2(DEPTH);
   localparam int CWID = $clog2(DEPTH + 1);

   if (NCH * RESERVE > DEPTH) begin : g_bad_reserve
      $error("syncfifo_shared_n: NCH*RESERVE exceeds DEPTH");
   end
   if (DEPTH < 2 || DEPTH > 64 || NCH < 1 || NCH > 16) begin : g_bad_size
      $error("syncfifo_shared_n: DEPTH or NCH out of range");
   end

   logic [WID-1:0]  pool_q [DEPTH];
   logic [DEPTH-1:0] free_q, free_d;
   logic [AWID-1:0] qptr_q [NCH][DEPTH];
   logic [AWID-1:0] qptr_d [NCH][DEPTH];
   logic [AWID-1:0] head_q [NCH];
   logic [AWID-1:0] head_d [NCH];
   logic [CWID-1:0] cnt_q  [NCH];
   logic [CWID-1:0] cnt_d  [NCH];
   logic [CWID-1:0] fcnt_q, fcnt_d;
   logic [1:0]      err_q, err_d;

   logic [NCH-1:0]   full_c, empty_c, acc, pop;
   logic [AWID-1:0]  slot [NCH];
   logic [DEPTH-1:0] taken;
   int               avail, owed, sl, t, sum;
   int               cntp [NCH];

   // Channels resolve in ascending order; each lower accept consumes a slot and may settle a debt.
   always_comb begin
      full_c = '0;
      acc    = '0;
      taken  = free_q;
      avail  = int'(fcnt_q);
      owed   = 0;
      sl     = 0;
      for (int j = 0; j < NCH; j++) begin
         cntp[j] = int'(cnt_q[j]);
         slot[j] = '0;
      end
      for (int i = 0; i < NCH; i++) begin
         owed = 0;
         for (int j = 0; j < NCH; j++) begin
            if (j != i && cntp[j] < RESERVE) owed = owed + (RESERVE - cntp[j]);
         end
         full_c[i] = (avail == 0) || ((int'(cnt_q[i]) >= RESERVE) && (avail <= owed));
         if (bus.vldin[i] && !full_c[i]) begin
            acc[i]  = 1'b1;
            avail   = avail - 1;
            cntp[i] = cntp[i] + 1;
            sl      = 0;
            for (int s = DEPTH - 1; s >= 0; s--) begin
               if (taken[s]) sl = s;
            end
            slot[i]   = AWID'(sl);
            taken[sl] = 1'b0;
         end
      end
   end

   always_comb begin
      free_d = free_q;
      qptr_d = qptr_q;
      head_d = head_q;
      cnt_d  = cnt_q;
      err_d  = err_q;
      pop    = '0;
      t      = 0;
      sum    = 0;
      for (int i = 0; i < NCH; i++) begin
         pop[i] = bus.readout[i] && !empty_c[i];
         if (pop[i]) begin
            free_d[qptr_q[i][head_q[i]]] = 1'b1;
            head_d[i] = (head_q[i] == AWID'(DEPTH - 1)) ? '0 : head_q[i] + 1'b1;
         end
         if (acc[i]) begin
            free_d[slot[i]] = 1'b0;
            t = int'(head_q[i]) + int'(cnt_q[i]);
            if (t >= DEPTH) t = t - DEPTH;
            qptr_d[i][AWID'(t)] = slot[i];
         end
         cnt_d[i] = cnt_q[i] + CWID'(acc[i]) - CWID'(pop[i]);
         sum = sum + int'(cnt_d[i]);
      end
      fcnt_d = CWID'(DEPTH - sum);
      err_d[0] = err_q[0] | (|(bus.vldin & full_c));
      err_d[1] = err_q[1] | (|(bus.readout & empty_c));
      if (softreset) begin
         free_d = '1;
         fcnt_d = CWID'(DEPTH);
         err_d  = '0;
         for (int i = 0; i < NCH; i++) begin
            head_d[i] = '0;
            cnt_d[i]  = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         free_q <= '1;
         fcnt_q <= CWID'(DEPTH);
         err_q  <= '0;
         for (int i = 0; i < NCH; i++) begin
            head_q[i] <= '0;
            cnt_q[i]  <= '0;
            for (int s = 0; s < DEPTH; s++) qptr_q[i][s] <= '0;
         end
      end else begin
         free_q <= free_d;
         fcnt_q <= fcnt_d;
         err_q  <= err_d;
         head_q <= head_d;
         cnt_q  <= cnt_d;
         qptr_q <= qptr_d;
      end
   end

   // Pool payload needs no reset: it is only read through an occupied pointer.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (acc[i] && !softreset) pool_q[slot[i]] <= bus.din[i*WID +: WID];
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         empty_c[i]                 = (cnt_q[i] == '0);
         bus.dout[i*WID +: WID]     = pool_q[qptr_q[i][head_q[i]]];
         bus.count[i*CWID +: CWID]  = cnt_q[i];
      end
   end

   assign bus.full       = full_c;
   assign bus.empty      = empty_c;
   assign bus.free_count = fcnt_q;
   assign bus.err        = err_q;
endmodule

// File: tb/tb_syncfifo_shared_n.sv
// tb/tb_syncfifo_shared_n.sv - scoreboard bench for syncfifo_shared_n
module tb_syncfifo_shared_n;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic softreset = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [31:0] expq [5][$];

   syncfifo_shared_n_if #(.WID(32), .DEPTH(8), .NCH(5)) bus();

   syncfifo_shared_n #(.WID(32), .DEPTH(8), .NCH(5), .RESERVE(1)) dut (
      .clk(clk), .rst(rst), .softreset(softreset), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every real pop must return the oldest expected word of that channel.
   always @(negedge clk) begin
      if (!rst && !softreset) begin
         for (int i = 0; i < 5; i++) begin
            if (bus.readout[i] && !bus.empty[i]) begin
               if (expq[i].size() == 0) begin
                  chk($sformatf("unexpected_pop_ch%0d", i), 32'h1, 32'h0);
               end else begin
                  chk($sformatf("dout_ch%0d", i), bus.dout[i*32 +: 32], expq[i].pop_front());
               end
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      bus.vldin   = '0;
      bus.readout = '0;
      softreset   = 1'b0;
   endtask

   task automatic wr(input int ch, input logic [31:0] d, input bit expect_acc);
      bus.vldin[ch]         = 1'b1;
      bus.din[ch*32 +: 32]  = d;
      if (expect_acc) expq[ch].push_back(d);
   endtask

   task automatic clear_exp();
      for (int i = 0; i < 5; i++) expq[i].delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.vldin = '0; bus.readout = '0; bus.din = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_empty", 32'(bus.empty), 32'h1f);
      chk("reset_full", 32'(bus.full), 32'h0);
      chk("reset_free", 32'(bus.free_count), 32'd8);

      // 1: async reset mid-stream discards held entries
      for (int k = 0; k < 3; k++) begin wr(1, 32'h10 + k, 1'b1); cyc(); end
      chk("pre_rst_count", 32'(bus.count), 32'h00030);
      #2 rst = 1'b1;
      #1;
      clear_exp();
      chk("rst_empty", 32'(bus.empty), 32'h1f);
      chk("rst_count", 32'(bus.count), 32'h0);
      chk("rst_free", 32'(bus.free_count), 32'd8);
      chk("rst_err", 32'(bus.err), 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      wr(1, 32'h55, 1'b1);
      chk("empty_same_cycle", 32'(bus.empty[1]), 32'h1);
      cyc();
      chk("empty_after_write", 32'(bus.empty[1]), 32'h0);
      bus.readout[1] = 1'b1; cyc();

      // 2: simultaneous allocation
      for (int i = 0; i < 5; i++) wr(i, 32'hA0 + i, 1'b1);
      cyc();
      chk("alloc_free", 32'(bus.free_count), 32'd3);
      chk("alloc_count", 32'(bus.count), 32'h11111);
      bus.readout = 5'b11111; cyc();
      chk("alloc_drain_free", 32'(bus.free_count), 32'd8);

      // 3: reservation keeps room for the other channels
      for (int k = 0; k < 4; k++) begin wr(0, 32'hB0 + k, 1'b1); cyc(); end
      chk("resv_full", 32'(bus.full), 32'h01);
      chk("resv_free", 32'(bus.free_count), 32'd4);
      wr(0, 32'hBF, 1'b0); cyc();
      chk("resv_drop_err", 32'(bus.err), 32'h1);
      chk("resv_drop_count", 32'(bus.count), 32'h00004);
      wr(3, 32'hC3, 1'b1); cyc();
      chk("resv_ch3_full", 32'(bus.full), 32'h09);
      chk("resv_ch3_count", 32'(bus.count), 32'h01004);
      wr(3, 32'hC4, 1'b0); cyc();
      chk("resv_ch3_drop", 32'(bus.count), 32'h01004);
      bus.readout = 5'b01001; cyc();
      for (int k = 0; k < 3; k++) begin bus.readout[0] = 1'b1; cyc(); end
      chk("resv_drain_free", 32'(bus.free_count), 32'd8);

      // 4: ordering with a slot freed and a write in the same cycle
      wr(2, 32'h11, 1'b1); cyc();
      wr(2, 32'h22, 1'b1); cyc();
      wr(2, 32'h33, 1'b1); cyc();
      bus.readout[2] = 1'b1; wr(2, 32'h44, 1'b1); cyc();
      chk("reuse_count", 32'(bus.count), 32'h00300);
      chk("reuse_free", 32'(bus.free_count), 32'd5);
      for (int k = 0; k < 3; k++) begin bus.readout[2] = 1'b1; cyc(); end

      // 5: pop on empty, push+pop on same channel
      wr(4, 32'h61, 1'b1); cyc();
      wr(4, 32'h62, 1'b1); cyc();
      bus.readout[1] = 1'b1; cyc();
      chk("empty_pop_err", 32'(bus.err), 32'h3);
      chk("empty_pop_count", 32'(bus.count), 32'h20000);
      bus.readout[4] = 1'b1; wr(4, 32'h63, 1'b1); cyc();
      chk("pushpop_count", 32'(bus.count), 32'h20000);
      for (int k = 0; k < 2; k++) begin bus.readout[4] = 1'b1; cyc(); end

      // 6: softreset wins over a same-cycle write
      wr(0, 32'h77, 1'b0); cyc();
      softreset = 1'b1; wr(0, 32'h88, 1'b0); cyc();
      chk("srst_count", 32'(bus.count), 32'h0);
      chk("srst_free", 32'(bus.free_count), 32'd8);
      chk("srst_err", 32'(bus.err), 32'h0);
      chk("srst_empty", 32'(bus.empty), 32'h1f);

      for (int i = 0; i < 5; i++) chk($sformatf("leftover_ch%0d", i), 32'(expq[i].size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
